// File: rtl/uart_tx_arbiter_if.sv
// Byte-source / transceiver handshake bundle shared by the TX arbiter.
// The master side is the environment (byte sources plus the transceiver's
// full flag); the slave side is the arbiter itself.
interface uart_tx_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic              txq_full;
    logic              send_req;
    logic [7:0]        send_data;

    modport master (
        output req_valid, req_data, req_last, txq_full,
        input  req_ready, send_req, send_data
    );

    modport slave (
        input  req_valid, req_data, req_last, txq_full,
        output req_ready, send_req, send_data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter in front of the UART TX byte queue.
// The winner owns the queue until it sends a byte flagged last, or until it
// has been idle for TIMEOUT consecutive cycles (TIMEOUT = 0 disables that).
module uart_tx_arbiter #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rstn,
    uart_tx_arbiter_if.slave bus,
    output logic [NREQ-1:0]  grant,
    output logic             busy,
    output logic             timeout_evt
);
    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Release happens on the edge that ends the TIMEOUT-th idle cycle, i.e.
    // when the counter is about to step from TIMEOUT-1 to TIMEOUT.
    localparam logic [CW-1:0] CNT_LAST  = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [OW-1:0] OWNER_MAX = OW'(NREQ - 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t          r_state, w_state_next;
    logic [OW-1:0]   r_owner, w_owner_next;
    logic [OW-1:0]   r_rr_ptr, w_rr_next;
    logic [CW-1:0]   r_cnt, w_cnt_next;
    logic [NREQ-1:0] r_grant, w_grant_next;
    logic            r_timeout_evt, w_timeout_evt_next;

    logic [7:0]      w_bytes    [NREQ];
    logic [OW-1:0]   w_scan_idx [NREQ];
    logic            w_found;
    logic [OW-1:0]   w_winner;
    logic [OW-1:0]   w_owner_inc;
    logic            w_owner_valid;
    logic            w_xfer;
    logic            w_timeout_hit;
    logic            w_send_req;
    logic [NREQ-1:0] w_req_ready;

    // Per-requester byte lanes and the rotated scan order starting at rr_ptr.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
        logic [OW:0] w_sum;
        assign w_bytes[gi]    = bus.req_data[8*gi +: 8];
        assign w_sum          = {1'b0, r_rr_ptr} + (OW+1)'(gi);
        assign w_scan_idx[gi] = (w_sum >= (OW+1)'(NREQ)) ? OW'(w_sum - (OW+1)'(NREQ))
                                                          : w_sum[OW-1:0];
    end

    assign w_owner_inc   = (r_owner == OWNER_MAX) ? '0 : r_owner + OW'(1);
    assign w_owner_valid = bus.req_valid[r_owner];
    // txq_full reflects a write one cycle later, so gating on it directly is
    // enough to never push into a full FIFO.
    assign w_xfer        = (r_state == ST_LOCKED) && w_owner_valid && !bus.txq_full;
    assign w_timeout_hit = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

    // Round-robin pick: walk the rotated order backwards so the first valid
    // requester at or after rr_ptr is the one left standing.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req_valid[w_scan_idx[i]]) begin
                w_found  = 1'b1;
                w_winner = w_scan_idx[i];
            end
        end
    end

    // Next-state and handshake outputs for the IDLE/LOCKED machine.
    always_comb begin
        w_state_next       = r_state;
        w_owner_next       = r_owner;
        w_rr_next          = r_rr_ptr;
        w_cnt_next         = r_cnt;
        w_grant_next       = r_grant;
        w_timeout_evt_next = 1'b0;
        w_send_req         = 1'b0;
        w_req_ready        = '0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_next = '0;
                if (w_found) begin
                    w_owner_next = w_winner;
                    w_grant_next = NREQ'(1) << w_winner;
                    w_state_next = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (w_xfer) begin
                    w_send_req  = 1'b1;
                    w_req_ready = NREQ'(1) << r_owner;
                    w_cnt_next  = '0;
                    if (bus.req_last[r_owner]) begin
                        w_state_next = ST_IDLE;
                        w_rr_next    = w_owner_inc;
                        w_grant_next = '0;
                    end
                end else if (!w_owner_valid) begin
                    if (w_timeout_hit) begin
                        w_state_next       = ST_IDLE;
                        w_rr_next          = w_owner_inc;
                        w_grant_next       = '0;
                        w_cnt_next         = '0;
                        w_timeout_evt_next = 1'b1;
                    end else if (r_cnt != {CW{1'b1}}) begin
                        w_cnt_next = r_cnt + CW'(1);
                    end
                end
                // Owner valid but FIFO full: backpressure, counter holds.
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State registers; reset abandons any packet in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= ST_IDLE;
            r_owner       <= '0;
            r_rr_ptr      <= '0;
            r_cnt         <= '0;
            r_grant       <= '0;
            r_timeout_evt <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_owner       <= w_owner_next;
            r_rr_ptr      <= w_rr_next;
            r_cnt         <= w_cnt_next;
            r_grant       <= w_grant_next;
            r_timeout_evt <= w_timeout_evt_next;
        end
    end

    assign bus.send_req  = w_send_req;
    assign bus.req_ready = w_req_ready;
    assign bus.send_data = (r_state == ST_LOCKED) ? w_bytes[r_owner] : 8'h00;
    assign grant         = r_grant;
    assign busy          = (r_state == ST_LOCKED);
    assign timeout_evt   = r_timeout_evt;
endmodule
